// File: rtl/audio_nios_onchip_memory3.sv
// Avalon-MM on-chip RAM for the audio Nios II: byte-lane writes, 1- or 2-stage pipelined reads,
// waitrequest back-pressure and an optional zero sweep after reset.
module audio_nios_onchip_memory3 #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    DEPTH          = 51200,
  parameter int    ADDR_WIDTH     = 16,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  // state | meaning
  // INIT  | zero sweep in progress (or waiting one edge when no sweep)
  // RUN   | normal Avalon traffic accepted
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int                  LANES    = DATA_WIDTH / 8;
  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [0:0]            state;
  logic [IDX_W-1:0]      sweep_idx;
  logic                  en;
  logic                  sweeping;
  logic                  in_range;
  logic                  acc_write;
  logic                  acc_read;
  logic                  ram_we;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      ram_idx;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [LANES-1:0]      ram_be;
  logic [DATA_WIDTH-1:0] rd_q1;
  logic                  vld_q1;
  logic                  unused_init;

  // Preload file is handed to the vendor RAM flow; it has no effect on the logic here.
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign unused_init = (INIT_FILE == "");

  assign en          = clken & ~reset_req;
  assign init_done   = (state == S_RUN);
  assign waitrequest = ~init_done | ~en;
  assign sweeping    = (state == S_INIT) && (CLEAR_ON_RESET != 0);
  assign in_range    = ({1'b0, address} < DEPTH_A);
  assign addr_idx    = address[IDX_W-1:0];
  assign acc_write   = chipselect & write & ~waitrequest;
  assign acc_read    = chipselect & read & ~write & ~waitrequest;

  // The sweep owns the write port while INIT; RAM is left alone while reset_n is low.
  assign ram_we    = en & reset_n & (sweeping | (acc_write & in_range));
  assign ram_idx   = sweeping ? sweep_idx : addr_idx;
  assign ram_wdata = sweeping ? '0 : writedata;
  assign ram_be    = sweeping ? '1 : byteenable;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (ram_be[i]) mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_INIT;
      sweep_idx <= '0;
    end else if (en) begin
      case (state)
        S_INIT: begin
          if ((CLEAR_ON_RESET == 0) || (sweep_idx == LAST_IDX)) state <= S_RUN;
          else sweep_idx <= sweep_idx + 1'b1;
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q1 <= 1'b0;
      rd_q1  <= '0;
    end else if (en) begin
      vld_q1 <= acc_read;
      if (acc_read) rd_q1 <= in_range ? mem[addr_idx] : '0;
    end
  end

  // A pulse is only shown in a cycle whose closing edge advances the pipe, so it is never repeated.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_q2;
      logic                  vld_q2;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          vld_q2 <= 1'b0;
          rd_q2  <= '0;
        end else if (en) begin
          vld_q2 <= vld_q1;
          if (vld_q1) rd_q2 <= rd_q1;
        end
      end

      assign readdata      = rd_q2;
      assign readdatavalid = vld_q2 & en;
    end else begin : g_lat1
      assign readdata      = rd_q1;
      assign readdatavalid = vld_q1 & en;
    end
  endgenerate

endmodule

// File: tb/tb_audio_nios_onchip_memory3.sv
// Bench for audio_nios_onchip_memory3: a latency-1 and a latency-2 instance share stimulus and
// are checked against a word-array/response-queue model plus directed vectors.
module tb_audio_nios_onchip_memory3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic        reset_req = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata1, rdata2;
  logic        rv1, rv2, wait1, wait2, done1, done2;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  audio_nios_onchip_memory3 #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .READ_LATENCY(1),
                              .CLEAR_ON_RESET(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address(addr), .byteenable(be), .chipselect(cs),
    .read(rd), .write(wr), .writedata(wdata), .clken(clken), .reset_req(reset_req),
    .readdata(rdata1), .readdatavalid(rv1), .waitrequest(wait1), .init_done(done1));

  audio_nios_onchip_memory3 #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .READ_LATENCY(2),
                              .CLEAR_ON_RESET(1), .INIT_FILE("")) u_lat2 (
    .clk(clk), .reset_n(reset_n), .address(addr), .byteenable(be), .chipselect(cs),
    .read(rd), .write(wr), .writedata(wdata), .clken(clken), .reset_req(reset_req),
    .readdata(rdata2), .readdatavalid(rv2), .waitrequest(wait2), .init_done(done2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, words left to clear, and responses tagged with en-edges since acceptance.
  typedef struct { logic [31:0] data; int age; } rsp_t;
  rsp_t        q[$];
  logic [31:0] mm [DEPTH];
  int          init_left = DEPTH;
  bit          en_m, en_n, v1e, v2e;

  always @(posedge clk) begin
    en_m = clken && !reset_req;
    if (!reset_n) begin
      q.delete();
      init_left = DEPTH;
    end else if (en_m) begin
      if (q.size() > 0 && q[0].age == 2) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) q[i].age++;
      if (init_left != 0) begin
        init_left--;
        if (init_left == 0) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end else if (cs && wr) begin
        if (addr < DEPTH)
          for (int b = 0; b < 4; b++) if (be[b]) mm[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
      end else if (cs && rd) begin
        q.push_back('{data: (addr < DEPTH) ? mm[addr[3:0]] : 32'h0, age: 1});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      en_n = clken && !reset_req;
      v1e  = en_n && q.size() > 0 && q[q.size()-1].age == 1;
      v2e  = en_n && q.size() > 0 && q[0].age == 2;
      chk("mon_wait1", 32'(wait1), 32'((init_left != 0) || !en_n));
      chk("mon_wait2", 32'(wait2), 32'((init_left != 0) || !en_n));
      chk("mon_done", 32'(done1 & done2), 32'(init_left == 0));
      chk("mon_valid1", 32'(rv1), 32'(v1e));
      chk("mon_valid2", 32'(rv2), 32'(v2e));
      if (v1e) chk("mon_data1", rdata1, q[q.size()-1].data);
      if (v2e) chk("mon_data2", rdata2, q[0].data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic w, input logic [4:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    cs = c; rd = r; wr = w; addr = a; be = b; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task automatic sweep_len(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wait1) n++;
      else break;
    end
    chk(name, n, DEPTH);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a <= DEPTH; a++) begin
      step();
      if (a < DEPTH) drive(1'b1, 1'b1, 1'b0, 5'(a), 4'h0, 32'h0);
      else idle();
      @(negedge clk);
      if (a >= 1) begin
        chk({name, "_v"}, 32'(rv1), 32'd1);
        chk({name, "_d"}, rdata1, 32'h0);
      end
    end
    step(); idle(); step();
  endtask

  typedef struct {
    logic        r, w;
    logic [4:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vt[8];

  initial begin
    int pulses, at;
    logic [31:0] got;

    vt[0] = '{1'b0, 1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 5'd5,  4'h1, 32'h000000AA, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 5'd5,  4'h0, 32'h0,        1'b1, 32'hDEADBEAA};
    vt[3] = '{1'b1, 1'b1, 5'd3,  4'hF, 32'h00000055, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 5'd3,  4'h0, 32'h0,        1'b1, 32'h00000055};
    vt[5] = '{1'b0, 1'b1, 5'd16, 4'hF, 32'h12345678, 1'b0, 32'h0};
    vt[6] = '{1'b1, 1'b0, 5'd16, 4'h0, 32'h0,        1'b1, 32'h0};
    vt[7] = '{1'b1, 1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 32'h0};

    @(posedge clk);
    #1 mon_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'({rv1, rv2}), 32'd0);
    chk("rst_done", 32'({done1, done2}), 32'd0);
    chk("rst_wait", 32'({wait1, wait2}), 32'd3);
    chk("rst_data1", rdata1, 32'h0);
    chk("rst_data2", rdata2, 32'h0);
    step();
    reset_n = 1'b1;
    sweep_len("sweep_len");
    read_all_zero("clear");

    foreach (vt[i]) begin
      step(); drive(1'b1, vt[i].r, vt[i].w, vt[i].a, vt[i].b, vt[i].d);
      step(); idle();
      @(negedge clk);
      chk($sformatf("vec%0d_v1", i), 32'(rv1), 32'(vt[i].exp_v));
      if (vt[i].exp_v) chk($sformatf("vec%0d_d1", i), rdata1, vt[i].exp_d);
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_v2", i), 32'(rv2), 32'(vt[i].exp_v));
      if (vt[i].exp_v) chk($sformatf("vec%0d_d2", i), rdata2, vt[i].exp_d);
    end

    step(); drive(1'b1, 1'b0, 1'b1, 5'd9, 4'hF, 32'hCAFEF00D);
    step(); drive(1'b1, 1'b1, 1'b0, 5'd9, 4'h0, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("raw_v1", 32'(rv1), 32'd1);
    chk("raw_d1", rdata1, 32'hCAFEF00D);

    for (int i = 0; i < 8; i++) begin
      step(); drive(1'b1, 1'b0, 1'b1, 5'(i), 4'hF, 32'h10 + 32'(i));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 8) drive(1'b1, 1'b1, 1'b0, 5'(k), 4'h0, 32'h0);
      else idle();
      @(negedge clk);
      if (k >= 1 && k <= 8) begin
        chk("b2b_v1", 32'(rv1), 32'd1);
        chk("b2b_d1", rdata1, 32'h10 + 32'(k - 1));
      end
      if (k >= 2) begin
        chk("b2b_v2", 32'(rv2), 32'd1);
        chk("b2b_d2", rdata2, 32'h10 + 32'(k - 2));
      end
    end

    // Stall a latency-2 read for three cycles: its single pulse slides from cycle 2 to cycle 5.
    step(); drive(1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0);
    pulses = 0; at = 0; got = '0;
    for (int c = 1; c <= 8; c++) begin
      step(); idle();
      clken = (c <= 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c <= 3) chk("stall_wait", 32'(wait2), 32'd1);
      if (rv2) begin pulses++; at = c; got = rdata2; end
    end
    chk("stall_pulses", pulses, 1);
    chk("stall_at", at, 5);
    chk("stall_data", got, 32'h12);

    for (int n = 0; n < 1500; n++) begin
      step();
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 17)), 4'($urandom), $urandom);
    end
    step(); idle(); clken = 1'b1; reset_req = 1'b0;
    repeat (3) step();

    step(); drive(1'b1, 1'b1, 1'b0, 5'd4, 4'h0, 32'h0);
    step(); idle(); reset_n = 1'b0;
    step(); reset_n = 1'b1;
    @(negedge clk);
    chk("rrst_done", 32'(done1), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (rv2) pulses++;
      @(negedge clk);
    end
    chk("rrst_no_pulse", pulses, 0);
    reset_n = 1'b0;
    step(); reset_n = 1'b1;
    sweep_len("rrst_sweep_len");
    read_all_zero("reclear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
